// File: rtl/cpu_fetch_pkg.sv
// cpu_fetch_pkg: shared fetch-stage types (FSM states, IF/ID record, NOP bubble encoding)
package cpu_fetch_pkg;
   typedef enum logic [1:0] {RUN, BUBBLE, HALT} state_t;
   localparam logic [31:0] NOP = 32'hD503201F;
   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        valid;
   } ifid_t;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with async reset, load enable and branch/sequential next-PC mux
//   clk, reset      : clock, async active-high reset (pc <= RESET_PC)
//   en              : update pc this cycle
//   load, target    : take target instead of pc+4 when load=1
//   pc              : current program counter
module fetch_pc_reg #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        load,
   input  logic [63:0] target,
   output logic [63:0] pc
);
   logic [63:0] nxt;
   always_comb nxt = load ? target : pc + 64'd4;
   always_ff @(posedge clk or posedge reset)
      if (reset) pc <= RESET_PC;
      else if (en) pc <= nxt;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage FSM (RUN/BUBBLE/HALT) driving a combinational imem and the IF/ID register
//   clk, reset                 : clock, async active-high reset
//   imem_addr / imem_instr     : byte address out (= pc), instruction word back in the same cycle
//   stall                      : freeze pc and IF/ID
//   br_taken / br_target       : redirect strobe and target
//   halt_req                   : stop fetching until reset
//   ifid_pc/ifid_instr/ifid_valid : IF/ID register contents
//   halted, fault              : in HALT, fetch fault latched
//   FETCH_FAULT_EN (macro)     : enables misaligned/out-of-bounds fault checking
module instr_fetch
   import cpu_fetch_pkg::*;
#(
   parameter int          IMEM_SIZE = 1024,
   parameter logic [63:0] RESET_PC  = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [63:0] br_target,
   input  logic        halt_req,
   output logic [63:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic        ifid_valid,
   output logic        halted,
   output logic        fault
);
   logic [63:0] pc;
   state_t      state;
   ifid_t       ifid;
   logic        flt, oob, flt_hit, stop, pc_en;
   // word pc..pc+3 must lie inside memory; compared without forming pc+3 so it cannot wrap
   assign oob = pc > 64'(IMEM_SIZE - 4);
`ifdef FETCH_FAULT_EN
   assign flt_hit = state != HALT && (pc[1:0] != 2'b00 || oob);
`else
   assign flt_hit = 1'b0;
`endif
   assign stop  = state == HALT || halt_req || flt_hit;
   // a branch overrides stall; halt/fault freeze the pc
   assign pc_en = !stop && (br_taken || !stall);
   fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk(clk), .reset(reset), .en(pc_en), .load(br_taken), .target(br_target), .pc(pc)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= RUN;
         ifid  <= '{pc: '0, instr: NOP, valid: 1'b0};
         flt   <= 1'b0;
      end else if (state != HALT) begin
         if (halt_req || flt_hit) begin
            state <= HALT;
            ifid  <= '{pc, NOP, 1'b0};
            flt   <= flt_hit;
         end else if (br_taken) begin
            state <= BUBBLE;
            ifid  <= '{pc, NOP, 1'b0};
         end else if (!stall) begin
            state <= RUN;
            ifid  <= '{pc, oob ? NOP : imem_instr, !oob};
         end
      end
   assign imem_addr  = pc;
   assign ifid_pc    = ifid.pc;
   assign ifid_instr = ifid.instr;
   assign ifid_valid = ifid.valid;
   assign halted     = state == HALT;
   assign fault      = flt;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with a 1 KiB pattern memory
module tb_instr_fetch;
   localparam logic [63:0] NOPW = 64'hD503201F;
   logic        clk = 1'b0, reset, stall, br_taken, halt_req;
   logic [63:0] imem_addr, br_target, ifid_pc;
   logic [31:0] imem_instr, ifid_instr;
   logic        ifid_valid, halted, fault;
   int          n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   // word k of memory reads 32'hA000_0000 + k; anything outside reads a poison value
   always_comb imem_instr = (imem_addr < 64'd1024) ? (32'hA000_0000 | 32'(imem_addr[9:2])) : 32'hDEAD_BEEF;
   instr_fetch dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
      .stall(stall), .br_taken(br_taken), .br_target(br_target), .halt_req(halt_req),
      .ifid_pc(ifid_pc), .ifid_instr(ifid_instr), .ifid_valid(ifid_valid),
      .halted(halted), .fault(fault)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_addr"}, imem_addr, 64'h0);
      chk({tag, "_ipc"}, ifid_pc, 64'h0);
      chk({tag, "_instr"}, 64'(ifid_instr), NOPW);
      chk({tag, "_valid"}, 64'(ifid_valid), 64'h0);
      chk({tag, "_halted"}, 64'(halted), 64'h0);
      chk({tag, "_fault"}, 64'(fault), 64'h0);
   endtask
   task automatic pulse_reset;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask
   initial begin
      reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0; halt_req = 1'b0;
      @(negedge clk);
      chk_reset_vals("rst");
      reset = 1'b0;
      step; chk("seq1_addr", imem_addr, 64'h4); chk("seq1_ipc", ifid_pc, 64'h0);
      chk("seq1_instr", 64'(ifid_instr), 64'hA0000000); chk("seq1_valid", 64'(ifid_valid), 64'h1);
      step; chk("seq2_addr", imem_addr, 64'h8); chk("seq2_ipc", ifid_pc, 64'h4);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step;
         chk("stall_addr", imem_addr, 64'h8); chk("stall_ipc", ifid_pc, 64'h4);
         chk("stall_instr", 64'(ifid_instr), 64'hA0000001); chk("stall_valid", 64'(ifid_valid), 64'h1);
      end
      stall = 1'b0;
      step; chk("unstall_addr", imem_addr, 64'hC); chk("unstall_ipc", ifid_pc, 64'h8);
      chk("unstall_instr", 64'(ifid_instr), 64'hA0000002);
      br_taken = 1'b1; br_target = 64'h40; stall = 1'b1;
      step; br_taken = 1'b0; stall = 1'b0;
      chk("br_addr", imem_addr, 64'h40); chk("br_valid", 64'(ifid_valid), 64'h0);
      chk("br_instr", 64'(ifid_instr), NOPW); chk("br_ipc", ifid_pc, 64'hC);
      step; chk("postbr_ipc", ifid_pc, 64'h40); chk("postbr_instr", 64'(ifid_instr), 64'hA0000010);
      chk("postbr_valid", 64'(ifid_valid), 64'h1); chk("postbr_addr", imem_addr, 64'h44);
      br_taken = 1'b1; br_target = 64'h20;
      step; br_taken = 1'b0; chk("br20_addr", imem_addr, 64'h20);
      halt_req = 1'b1;
      step; halt_req = 1'b0;
      chk("halt_halted", 64'(halted), 64'h1); chk("halt_addr", imem_addr, 64'h20);
      chk("halt_valid", 64'(ifid_valid), 64'h0);
      br_taken = 1'b1; br_target = 64'h100;
      step; step; br_taken = 1'b0;
      chk("halt_br_addr", imem_addr, 64'h20); chk("halt_br_halted", 64'(halted), 64'h1);
      #2 reset = 1'b1;
      #1 chk("hrst_addr", imem_addr, 64'h0); chk("hrst_halted", 64'(halted), 64'h0);
      @(negedge clk); reset = 1'b0;
      step; chk("restart_addr", imem_addr, 64'h4); chk("restart_ipc", ifid_pc, 64'h0);
      chk("restart_valid", 64'(ifid_valid), 64'h1);
      br_taken = 1'b1; br_target = 64'h80;
      step; br_taken = 1'b0; chk("bub_addr", imem_addr, 64'h80);
      #2 reset = 1'b1;
      #1 chk_reset_vals("bubrst");
      @(negedge clk); reset = 1'b0;
      br_taken = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
      step; br_taken = 1'b0; chk("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      step;
`ifdef FETCH_FAULT_EN
      chk("wrap_fault", 64'(fault), 64'h1); chk("wrap_halted", 64'(halted), 64'h1);
      chk("wrap_hold", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
`else
      chk("wrap_addr2", imem_addr, 64'h0); chk("wrap_ipc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_instr", 64'(ifid_instr), NOPW); chk("wrap_valid", 64'(ifid_valid), 64'h0);
      step; chk("wrap_addr3", imem_addr, 64'h4); chk("wrap_ipc3", ifid_pc, 64'h0);
      chk("wrap_instr3", 64'(ifid_instr), 64'hA0000000);
`endif
      pulse_reset;
      br_taken = 1'b1; br_target = 64'd1022;
      step; br_taken = 1'b0; chk("f_addr", imem_addr, 64'd1022);
      step;
      chk("f_instr", 64'(ifid_instr), NOPW); chk("f_valid", 64'(ifid_valid), 64'h0);
`ifdef FETCH_FAULT_EN
      chk("f_fault", 64'(fault), 64'h1); chk("f_halted", 64'(halted), 64'h1);
      chk("f_hold", imem_addr, 64'd1022);
`else
      chk("f_fault", 64'(fault), 64'h0); chk("f_halted", 64'(halted), 64'h0);
      chk("f_addr2", imem_addr, 64'd1026); chk("f_ipc", ifid_pc, 64'd1022);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter IMEM_SIZE, default 1024, SHALL be the instruction memory size in bytes; it is a power of two and greater than 4.
REQ-002 Parameter RESET_PC, default 64'h0, SHALL be the PC value loaded on reset.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on posedge clk.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 imem_addr  output  64  SHALL be the byte address driven to the combinational instruction memory, equal to the current PC.
REQ-006 imem_instr  input  32  SHALL be the instruction word returned for imem_addr in the same cycle.
REQ-007 stall  input  1  SHALL be the downstream hold request: freeze PC and IF/ID.
REQ-008 br_taken  input  1  SHALL be the resolved-taken branch redirect strobe.
REQ-009 br_target  input  64  SHALL be the redirect byte address, sampled when br_taken=1.
REQ-010 halt_req  input  1  SHALL be the request to stop fetching permanently until reset.
REQ-011 ifid_pc  output  64  SHALL be the PC of the instruction held in IF/ID.
REQ-012 ifid_instr  output  32  SHALL be the instruction held in IF/ID.
REQ-013 ifid_valid  output  1  SHALL be high when IF/ID holds a real instruction rather than a bubble.
REQ-014 halted  output  1  SHALL be high while the FSM is in HALT.
REQ-015 fault  output  1  SHALL be high while a fetch fault is latched (REQ-028).

Function
REQ-016 The FSM states SHALL be RUN, BUBBLE and HALT.
REQ-017 Event priority each cycle SHALL be: reset > halt_req/fault > br_taken > stall > normal advance.
REQ-018 RUN, no event: PC <= PC+4; IF/ID <= {PC, imem_instr, valid=1}; zero added latency, so fetch-to-IF/ID is 1 cycle.
REQ-019 stall=1 with no higher-priority event: PC, IF/ID and state SHALL hold unchanged.
REQ-020 br_taken=1 in RUN or BUBBLE: PC <= br_target; IF/ID <= {PC, NOP, valid=0}; next state BUBBLE, even if stall=1 in the same cycle.
REQ-021 BUBBLE: the bubble SHALL persist one cycle, then behave as RUN; a new br_taken in BUBBLE re-enters BUBBLE.
REQ-022 halt_req=1 in any state: next state HALT; IF/ID <= bubble; PC holds.
REQ-023 HALT: PC, IF/ID and state SHALL hold; all inputs are ignored except reset.
REQ-024 PC arithmetic SHALL be 64-bit unsigned, and PC+4 SHALL wrap modulo 2^64 without error.
REQ-025 The bubble encoding SHALL be the A64 NOP, 32'hD503201F.
REQ-026 ifid_instr SHALL never be taken from imem_instr when imem_addr is out of bounds; a bubble is substituted.

Reset
REQ-027 On reset: PC=RESET_PC, state=RUN, ifid_pc=0, ifid_instr=NOP, ifid_valid=0, halted=0, fault=0. Reset asserted mid-operation (including in HALT) SHALL take effect immediately; fetch restarts at RESET_PC on the first posedge after deassertion.

Configuration
REQ-028 With FETCH_FAULT_EN defined, the block SHALL check the PC as follows:
- Fault condition: PC[1:0]!=0, or PC+3 >= IMEM_SIZE, in RUN or BUBBLE.
- Response: latch fault=1, go to HALT, load a bubble into IF/ID.
- Precedence: the fault SHALL take priority over br_taken and stall.
REQ-029 Without FETCH_FAULT_EN, fault SHALL be tied to 0 and no fault checking SHALL occur. Out-of-bounds fetches still substitute a bubble per REQ-026, but the FSM does not halt.

Structure
REQ-030 The shared package cpu_fetch_pkg SHALL hold:
- the state enum;
- the NOP constant;
- the IF/ID struct {pc, instr, valid}.
REQ-031 The sub-module fetch_pc_reg SHALL hold the PC register with async reset, the load-enable (stall) and the next-PC mux; instr_fetch holds the FSM and IF/ID register.

Verification
REQ-032 Reset released, no events, 4 cycles -> imem_addr 0,4,8,12; ifid_pc 0,4,8 with ifid_valid=1 from cycle 2.
REQ-033 stall=1 for 3 cycles at PC=8 -> imem_addr stays 8, IF/ID stays {4, mem[1], 1}; advances to 12 after stall drops.
REQ-034 br_taken=1, br_target=64'h40, stall=1 at PC=12 -> next imem_addr=0x40, ifid_valid=0, ifid_instr=32'hD503201F; the following cycle IF/ID={0x40, mem[16], 1}.
REQ-035 halt_req pulse at PC=0x20, then br_taken pulses -> halted=1 and PC frozen at 0x20; reset then gives PC=0 and halted=0.
REQ-036 FETCH_FAULT_EN, br_target=1022 -> fault=1 and halted=1 the cycle after the PC loads 1022; without the macro, fault stays 0 and ifid_instr is the NOP bubble.
REQ-037 Reset asserted asynchronously mid-cycle during BUBBLE -> all outputs take their REQ-027 values before the next posedge.
